pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised elastic pipeline register between two CPU stages (IF/ID and later boundaries).
//   Replaces the fixed 2x32-bit stall register with a valid/ready handshake.
//   A 2-entry skid buffer keeps in_ready registered, so no combinational ready path crosses the stage.
//   Flush inserts a bubble whose data is forced to NOP_DATA.
// PARAMETERS
//   DATA_W    64      payload width in bits; IF/ID packs {pc[31:0], instr[31:0]}
//   NOP_DATA  '0      out_data value presented while the stage is empty or flushed
// PORTS
//   clk         in   1        clock; all state updates on posedge
//   rst         in   1        reset, synchronous, active-high
//   flush       in   1        discard all held entries this cycle (branch/jump redirect)
//   in_valid    in   1        upstream presents in_data
//   in_ready    out  1        stage can accept; registered output
//   in_data     in   DATA_W   upstream payload
//   out_valid   out  1        out_data holds a live entry
//   out_ready   in   1        downstream consumes this cycle; low = stall
//   out_data    out  DATA_W   payload to downstream
//   stall_cnt   out  32       [PIPE_STAGE_STATS_EN only] cycles with out_valid & !out_ready
//   flush_cnt   out  32       [PIPE_STAGE_STATS_EN only] flush cycles that killed >=1 live entry
// BEHAVIOUR
//   Handshake: a transfer occurs on a posedge with valid & ready on the same side. The sender holds data stable until the transfer.
//   Reset values: out_valid=0, out_data=NOP_DATA, in_ready=1, both entries invalid, counters=0.
//   Priority per cycle: rst > flush > normal operation.
//   States, encoded by {skid_v, main_v}:
//     EMPTY: in_valid -> FULL (main<=in_data).
//     FULL:  out_ready & in_valid -> FULL (main replaced).
//            out_ready & !in_valid -> EMPTY.
//            !out_ready & in_valid -> SKID (skid<=in_data).
//     SKID:  in_ready=0.
//            out_ready -> FULL (main<=skid); otherwise hold both entries.
//   Latency: 1 cycle from an in transfer to out_valid when downstream is not stalled. Throughput is 1 per cycle.
//   in_ready = !skid_v, registered. The stall is seen upstream one cycle after out_ready drops; the skid entry absorbs the in-flight beat.
//   Flush: next cycle state is EMPTY, out_data=NOP_DATA, in_ready=1.
//     An in transfer in the flush cycle is dropped.
//     A flush coinciding with out_ready still consumes the current entry downstream (the transfer happens); the held entries are cleared afterwards.
//   Data ordering strictly FIFO; no entry is duplicated or lost except by flush.
//   out_data = NOP_DATA whenever out_valid=0. Downstream may ignore valid and decode a NOP.
//   rst asserted mid-stall (SKID): both entries dropped, EMPTY next cycle.
// CONFIGURATION
//   PIPE_STAGE_STATS_EN defined:
//     stall_cnt and flush_cnt ports exist. Counters saturate at 32'hFFFF_FFFF and clear on rst only (flush does not clear them).
//   Not defined: the ports and counters are absent; the datapath behaviour is identical.
// STRUCTURE
//   pipe_pkg:
//     NOP_INSTR (32'h0000_0000) and PC_W/INSTR_W constants.
//     if_id_t packed struct {pc, instr}.
//     pipe_state_e enum {EMPTY, FULL, SKID}.
//   No sub-module: a single always block for the state/entries and a single always block for the optional counters.
// TESTING
//   1. Stream 8 words 0x10..0x17 with in_valid=1 and out_ready=1
//      -> out_valid after 1 cycle; outputs 0x10..0x17 in order, one per cycle; in_ready stays 1.
//   2. Drop out_ready for 3 cycles mid-stream
//      -> state reaches SKID; in_ready=0 the cycle after; no word lost or repeated.
//   3. Assert flush while in SKID, with in_valid=1 (data 0xAA)
//      -> next cycle out_valid=0, out_data=NOP_DATA, in_ready=1; 0xAA never appears.
//   4. Assert flush together with out_ready in FULL
//      -> current entry is consumed; stage is empty after.
//   5. Assert rst for 1 cycle while in SKID
//      -> all outputs at reset values next cycle; a new stream restarts cleanly.
//   6. With PIPE_STAGE_STATS_EN: 5 stall cycles plus 2 flushes (1 while empty)
//      -> stall_cnt=5, flush_cnt=1. Rebuild without the macro: the ports are gone and tests 1-5 pass.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types and constants for the CPU stage registers.
// Optional statistics in pipe_stage_reg are enabled by defining PIPE_STAGE_STATS_EN.
package pipe_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID payload: program counter in the upper half, instruction word below.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  // Occupancy view of the stage, encoded as {skid_v, main_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer between two CPU stages.
// in_ready is taken straight from a flop, so no combinational ready path
// crosses the stage boundary. Flush empties the stage and presents NOP_DATA.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt / flush_cnt statistics ports.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = PC_W + INSTR_W,
  parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_data_p1;
  logic [DATA_W-1:0] skid_data_p1;
  pipe_state_e       state;

  // Saturating +1 used by the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign state = pipe_state_e'({skid_v, main_v});

  // ---- stage boundary: registered entries drive the downstream side ----
  assign out_valid = main_v;
  assign out_data  = main_v ? main_data_p1 : NOP_DATA;
  assign in_ready  = !skid_v;

  // Occupancy flags and entry payloads; payload flops carry no reset because
  // they are only ever observed through the valid flags.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_v       <= 1'b1;
            main_data_p1 <= in_data;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) main_data_p1 <= in_data;
            else          main_v       <= 1'b0;
          end else if (in_valid) begin
            // Downstream stalled while a beat was in flight: park it.
            skid_v       <= 1'b1;
            skid_data_p1 <= in_data;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_data_p1 <= skid_data_p1;
            skid_v       <= 1'b0;
          end
        end
        default: begin
          // {skid_v, main_v} = 2'b10 is unreachable; recover to EMPTY.
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic kill;

  // A flush kills an entry unless that entry is leaving downstream this cycle.
  assign kill = flush && (skid_v || (main_v && !out_ready));

  // Stall and flush statistics; cleared only by rst, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_v && !out_ready) stall_cnt <= sat_inc(stall_cnt);
      if (kill)                 flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule
